// File: rtl/msi_miss_handler.sv
// msi_miss_handler: MSI miss bus engine. It optionally writes back the victim line, then issues
// read/readex/upgrade with NACK backoff/retry, and returns fill data and the final line state.
module msi_miss_handler #(
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128,
   parameter int MAX_RETRY = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic              req_writeback,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_state,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [LINE_W-1:0] victim_data,
   output logic              bus_req,
   output logic              bus_write,
   output logic [1:0]        bus_cmd,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [LINE_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic              bus_nack,
   input  logic [LINE_W-1:0] bus_rdata,
   output logic              done,
   output logic              done_error,
   output logic              fill_valid,
   output logic [LINE_W-1:0] fill_data,
   output logic [1:0]        fill_state
);
   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_UPGRADE = 2'd3;
   localparam logic [1:0] ST_I = 2'd0;

   typedef enum logic [2:0] {IDLE, WB, CMD, BACKOFF, DONE} state_t;

   state_t            state;
   logic [1:0]        r_cmd;
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        retry;
   logic              last_try;
   logic              fill_cmd;

   assign req_ready = state == IDLE;
   assign last_try  = retry == 4'(MAX_RETRY - 1);
   assign fill_cmd  = r_cmd != CMD_NONE && r_cmd != CMD_UPGRADE;

   // bus_write stays valid through BACKOFF, so it selects which phase to re-enter
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= IDLE;
         r_cmd      <= CMD_NONE;
         r_state    <= ST_I;
         r_addr     <= '0;
         retry      <= '0;
         bus_req    <= 1'b0;
         bus_write  <= 1'b0;
         bus_cmd    <= CMD_NONE;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         done       <= 1'b0;
         done_error <= 1'b0;
         fill_valid <= 1'b0;
         fill_data  <= '0;
         fill_state <= ST_I;
      end else begin
         done       <= 1'b0;
         done_error <= 1'b0;
         fill_valid <= 1'b0;
         case (state)
            IDLE:
               if (req_valid) begin
                  r_cmd   <= req_cmd;
                  r_addr  <= req_addr;
                  r_state <= req_state;
                  retry   <= '0;
                  if (req_writeback) begin
                     state     <= WB;
                     bus_req   <= 1'b1;
                     bus_write <= 1'b1;
                     bus_cmd   <= CMD_NONE;
                     bus_addr  <= victim_addr;
                     bus_wdata <= victim_data;
                  end else if (req_cmd != CMD_NONE) begin
                     state     <= CMD;
                     bus_req   <= 1'b1;
                     bus_write <= 1'b0;
                     bus_cmd   <= req_cmd;
                     bus_addr  <= req_addr;
                  end else begin
                     state      <= DONE;
                     done       <= 1'b1;
                     fill_state <= req_state;
                  end
               end
            WB, CMD:
               if (bus_ack) begin
                  retry <= '0;
                  if (state == WB && r_cmd != CMD_NONE) begin
                     state     <= CMD;
                     bus_write <= 1'b0;
                     bus_cmd   <= r_cmd;
                     bus_addr  <= r_addr;
                  end else begin
                     state      <= DONE;
                     bus_req    <= 1'b0;
                     done       <= 1'b1;
                     fill_state <= r_state;
                     fill_valid <= state == CMD && fill_cmd;
                     if (state == CMD && fill_cmd)
                        fill_data <= bus_rdata;
                  end
               end else if (bus_nack) begin
                  bus_req <= 1'b0;
                  if (last_try) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     done_error <= 1'b1;
                     fill_state <= ST_I;
                  end else begin
                     state <= BACKOFF;
                     retry <= retry + 4'd1;
                  end
               end
            BACKOFF: begin
               state   <= bus_write ? WB : CMD;
               bus_req <= 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_msi_miss_handler.sv
// tb_msi_miss_handler: randomized bench for msi_miss_handler. A scripted bus responder plays
// against an arithmetic model of phase counts, retry costs and fill results.
module tb_msi_miss_handler;
   localparam int MAXR = 4;

   typedef struct packed {
      int           cyc;
      int           reqs;
      logic         err;
      logic         fv;
      logic [1:0]   fs;
      logic [127:0] fd;
      int           bad;
   } res_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   req_cmd = '0;
   logic         req_writeback = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [1:0]   req_state = '0;
   logic [31:0]  victim_addr = '0;
   logic [127:0] victim_data = '0;
   logic         bus_req, bus_write;
   logic [1:0]   bus_cmd;
   logic [31:0]  bus_addr;
   logic [127:0] bus_wdata;
   logic         bus_ack = 1'b0, bus_nack = 1'b0;
   logic [127:0] bus_rdata = '0;
   logic         done, done_error, fill_valid;
   logic [127:0] fill_data;
   logic [1:0]   fill_state;

   int           tests = 0;
   int           fails = 0;
   logic [127:0] m_fill = '0;

   always #5 clk = ~clk;

   msi_miss_handler #(.ADDR_W(32), .LINE_W(128), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_writeback(req_writeback), .req_addr(req_addr),
      .req_state(req_state), .victim_addr(victim_addr), .victim_data(victim_data),
      .bus_req(bus_req), .bus_write(bus_write), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_nack(bus_nack), .bus_rdata(bus_rdata),
      .done(done), .done_error(done_error), .fill_valid(fill_valid), .fill_data(fill_data),
      .fill_state(fill_state)
   );

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Each phase costs (attempts x hold cycles) of bus_req plus one backoff per retried attempt.
   function automatic res_t model(input logic [1:0] cmd, input logic wb, input logic [1:0] st,
                                  input int wbn, input int cmdn, input int d, input logic [127:0] rd);
      res_t e;
      int n[$];
      int tries;
      e = '0;
      e.cyc = 1;
      if (wb) n.push_back(wbn);
      if (cmd != 2'd0) n.push_back(cmdn);
      foreach (n[i]) begin
         tries = (n[i] >= MAXR) ? MAXR : n[i] + 1;
         e.reqs += tries * (d + 1);
         e.cyc += tries * (d + 1) + tries - 1;
         if (n[i] >= MAXR) begin
            e.err = 1'b1;
            break;
         end
      end
      e.fv = !e.err && (cmd == 2'd1 || cmd == 2'd2);
      e.fs = e.err ? 2'd0 : st;
      e.fd = e.fv ? rd : m_fill;
      return e;
   endfunction

   // Drives one request and plays the bus; records what the DUT did, without judging the result.
   task automatic run_txn(input logic [1:0] cmd, input logic wb, input logic [31:0] addr,
                          input logic [1:0] st, input logic [31:0] va, input logic [127:0] vd,
                          input int wbn, input int cmdn, input int d, input logic both,
                          input logic [127:0] rd, output res_t r);
      int   pi, att, hold, nph;
      logic pw[3];
      int   pn[3];
      logic seen;
      nph = 0;
      pw = '{1'b0, 1'b0, 1'b0};
      pn = '{0, 0, 0};
      if (wb) begin pw[nph] = 1'b1; pn[nph] = wbn; nph++; end
      if (cmd != 2'd0) begin pw[nph] = 1'b0; pn[nph] = cmdn; nph++; end
      r = '0;
      r.cyc = -1;
      pi = 0; att = 0; hold = 0; seen = 1'b0;
      @(negedge clk);
      if (!req_ready) r.bad++;
      req_valid = 1'b1; req_cmd = cmd; req_writeback = wb; req_addr = addr;
      req_state = st; victim_addr = va; victim_data = vd;
      bus_ack = $urandom; bus_nack = $urandom;
      for (int cyc = 1; cyc < 200; cyc++) begin
         @(negedge clk);
         req_cmd = 2'($urandom); req_writeback = 1'($urandom); req_addr = $urandom;
         req_state = 2'($urandom); victim_addr = $urandom; victim_data = rnd128();
         bus_rdata = rnd128();
         if (done) begin
            r.cyc = cyc; r.err = done_error; r.fv = fill_valid; r.fs = fill_state; r.fd = fill_data;
            if (req_ready || bus_req) r.bad++;
            req_valid = 1'b0; bus_ack = 1'b0; bus_nack = 1'b0;
            seen = 1'b1;
            break;
         end
         if (req_ready) r.bad++;
         if (bus_req) begin
            r.reqs++;
            if (pi >= nph || bus_write !== pw[pi] || bus_addr !== (pw[pi] ? va : addr) ||
                bus_cmd !== (pw[pi] ? 2'd0 : cmd) || (pw[pi] && bus_wdata !== vd)) r.bad++;
            if (hold < d) begin
               hold++; bus_ack = 1'b0; bus_nack = 1'b0;
            end else begin
               hold = 0;
               if (pi < nph && att < pn[pi]) begin
                  bus_ack = 1'b0; bus_nack = 1'b1; att++;
               end else begin
                  bus_ack = 1'b1; bus_nack = both; bus_rdata = rd; att = 0; pi++;
               end
            end
         end else begin
            bus_ack = $urandom; bus_nack = $urandom;
         end
      end
      req_valid = 1'b0;
      if (seen) begin
         @(negedge clk);
         if (done || !req_ready) r.bad++;
      end
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if (req_ready !== 1'b1 || bus_req !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got ready=%b bus_req=%b done=%b, want 1 0 0", req_ready, bus_req, done);
      end
      tests++;
      if (fill_state !== 2'd0 || fill_data !== '0 || bus_addr !== '0 || bus_wdata !== '0 || bus_cmd !== 2'd0) begin
         fails++;
         $display("FAIL reset_data: got fs=%0d fd=%h addr=%h cmd=%0d, want zeros", fill_state, fill_data, bus_addr, bus_cmd);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_read();
      res_t r, e;
      e = model(2'd1, 1'b0, 2'd1, 0, 0, 0, {16{8'hA5}});
      run_txn(2'd1, 1'b0, 32'h1000, 2'd1, $urandom, rnd128(), 0, 0, 0, 1'b0, {16{8'hA5}}, r);
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL read: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.fd, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs, e.fd);
      end
      tests++;
      if (r.cyc !== 2 || r.fd !== {16{8'hA5}}) begin
         fails++;
         $display("FAIL read_latency: got cyc=%0d fd=%h, want 2 a5..a5", r.cyc, r.fd);
      end
      m_fill = e.fd;
   endtask

   task automatic test_writeback();
      res_t r, e;
      logic [127:0] vd, rd;
      vd = rnd128(); rd = rnd128();
      e = model(2'd2, 1'b1, 2'd2, 0, 0, 0, rd);
      run_txn(2'd2, 1'b1, 32'h3000, 2'd2, 32'h2000, vd, 0, 0, 0, 1'b0, rd, r);
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL writeback: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.fd, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs, e.fd);
      end
      m_fill = e.fd;
   endtask

   task automatic test_upgrade();
      res_t r, e;
      logic [127:0] prev;
      prev = m_fill;
      e = model(2'd3, 1'b0, 2'd2, 0, 0, 1, {128{1'b1}});
      run_txn(2'd3, 1'b0, 32'h1040, 2'd2, $urandom, rnd128(), 0, 0, 1, 1'b0, {128{1'b1}}, r);
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL upgrade: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d fd=%h",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.fd, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs, e.fd);
      end
      tests++;
      if (r.fd !== prev || r.fv !== 1'b0 || r.fs !== 2'd2) begin
         fails++;
         $display("FAIL upgrade_hold: got fd=%h fv=%b fs=%0d, want fd=%h fv=0 fs=2", r.fd, r.fv, r.fs, prev);
      end
      m_fill = e.fd;
   endtask

   task automatic test_nack_retry();
      res_t r, e;
      logic [127:0] rd;
      rd = rnd128();
      e = model(2'd1, 1'b0, 2'd1, 0, 2, 0, rd);
      run_txn(2'd1, 1'b0, 32'h5000, 2'd1, $urandom, rnd128(), 0, 2, 0, 1'b0, rd, r);
      tests++;
      if (r !== e || r.cyc !== 6 || r.reqs !== 3) begin
         fails++;
         $display("FAIL nack_retry: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs);
      end
      m_fill = e.fd;
   endtask

   task automatic test_wb_error();
      res_t r, e;
      e = model(2'd2, 1'b1, 2'd2, MAXR, 0, 0, '0);
      run_txn(2'd2, 1'b1, 32'h6000, 2'd2, 32'h7000, rnd128(), MAXR, 0, 0, 1'b0, '0, r);
      tests++;
      if (r !== e || r.err !== 1'b1 || r.fs !== 2'd0 || r.reqs !== MAXR) begin
         fails++;
         $display("FAIL wb_error: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs);
      end
      m_fill = e.fd;
   endtask

   task automatic test_ack_nack_and_none();
      res_t r, e;
      logic [127:0] rd;
      rd = rnd128();
      e = model(2'd2, 1'b0, 2'd2, 0, 0, 0, rd);
      run_txn(2'd2, 1'b0, 32'h8000, 2'd2, $urandom, rnd128(), 0, 0, 0, 1'b1, rd, r);
      tests++;
      if (r !== e) begin
         fails++;
         $display("FAIL ack_nack: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d",
                  r.cyc, r.reqs, r.err, r.fv, r.fs, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs);
      end
      m_fill = e.fd;
      e = model(2'd0, 1'b0, 2'd1, 0, 0, 0, '0);
      run_txn(2'd0, 1'b0, 32'h9000, 2'd1, $urandom, rnd128(), 0, 0, 0, 1'b0, '0, r);
      tests++;
      if (r !== e || r.cyc !== 1) begin
         fails++;
         $display("FAIL no_cmd: got cyc=%0d reqs=%0d fv=%b fs=%0d bad=%0d, want cyc=1 reqs=0 fv=0 fs=%0d",
                  r.cyc, r.reqs, r.fv, r.fs, r.bad, e.fs);
      end
      m_fill = e.fd;
   endtask

   task automatic test_random();
      res_t r, e;
      logic [1:0] cmd, st;
      logic wb, both;
      int wbn, cmdn, d;
      logic [127:0] rd;
      for (int i = 0; i < 40; i++) begin
         cmd = 2'($urandom_range(0, 3)); wb = 1'($urandom); st = 2'($urandom_range(0, 2));
         wbn = $urandom_range(0, MAXR); cmdn = $urandom_range(0, MAXR);
         d = $urandom_range(0, 2); both = 1'($urandom); rd = rnd128();
         e = model(cmd, wb, st, wbn, cmdn, d, rd);
         run_txn(cmd, wb, $urandom, st, $urandom, rnd128(), wbn, cmdn, d, both, rd, r);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL random[%0d] cmd=%0d wb=%b n=%0d/%0d d=%0d: got cyc=%0d reqs=%0d err=%b fv=%b fs=%0d bad=%0d, want cyc=%0d reqs=%0d err=%b fv=%b fs=%0d",
                     i, cmd, wb, wbn, cmdn, d, r.cyc, r.reqs, r.err, r.fv, r.fs, r.bad, e.cyc, e.reqs, e.err, e.fv, e.fs);
         end
         m_fill = e.fd;
      end
   endtask

   task automatic test_async_reset();
      int pulses;
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 2'd1; req_writeback = 1'b0; req_addr = 32'hA000; req_state = 2'd1;
      bus_ack = 1'b0; bus_nack = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      tests++;
      if (bus_req !== 1'b1) begin
         fails++;
         $display("FAIL abort_setup: got bus_req=%b, want 1", bus_req);
      end
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (bus_req !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL abort: got bus_req=%b ready=%b done=%b, want 0 1 0", bus_req, req_ready, done);
      end
      m_fill = '0;
      @(negedge clk);
      reset_n = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || bus_req) pulses++;
      end
      tests++;
      if (pulses !== 0 || fill_data !== m_fill) begin
         fails++;
         $display("FAIL abort_quiet: got %0d done/bus_req cycles fd=%h, want 0 and %h", pulses, fill_data, m_fill);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_writeback();
      test_upgrade();
      test_nack_retry();
      test_wb_error();
      test_ack_nack_and_none();
      test_random();
      test_async_reset();
      test_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/msi_miss_handler.md
Name: msi_miss_handler

Overview:
- Sequential bus-transaction engine directly downstream of the MSI protocol decode in the processor cache.
- Accepts one miss request per transaction: command, writeback flag and next state.
- Optionally writes back the dirty victim line, then issues read/readex/upgrade on the shared bus with NACK retry.
- Returns fill data and the final line state to the cache.

Parameters:
ADDR_W, 32, byte address width of line addresses
LINE_W, 128, cache line width in bits
MAX_RETRY, 4, NACKs tolerated per bus phase before error (1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  miss request valid
req_ready  output  1  handler idle, request accepted when valid&ready
req_cmd  input  2  bus command: 0 none, bus_read, bus_readex, bus_upgrade (bus_package encodings)
req_writeback  input  1  victim line must be written back first
req_addr  input  ADDR_W  missing line address
req_state  input  2  MSI state to install (I/S/M, cache_package)
victim_addr  input  ADDR_W  victim line address
victim_data  input  LINE_W  victim line data
bus_req  output  1  bus transaction request, held until ack/nack
bus_write  output  1  1 = writeback phase, 0 = command phase
bus_cmd  output  2  command, 0 during writeback phase
bus_addr  output  ADDR_W  transaction address
bus_wdata  output  LINE_W  writeback data
bus_ack  input  1  transaction completed (sampled only while bus_req=1)
bus_nack  input  1  transaction refused (sampled only while bus_req=1)
bus_rdata  input  LINE_W  read data, valid with bus_ack in command phase
done  output  1  one-cycle completion pulse
done_error  output  1  with done: retry limit exhausted
fill_valid  output  1  with done: fill_data is valid (read/readex only)
fill_data  output  LINE_W  captured line data
fill_state  output  2  state to install; I on error

Behaviour:
- Reset (async, reset_n=0): state IDLE; bus_req, bus_write, done, done_error, fill_valid = 0; bus_cmd, bus_addr, bus_wdata, fill_data = 0; fill_state = I; retry counter = 0. req_ready = (state==IDLE), so it reads 1 during reset.
- Reset mid-transaction: immediate abort, no done pulse; the bus sees bus_req drop asynchronously.
- FSM states: IDLE, WB, CMD, BACKOFF, DONE.
- IDLE: on req_valid&req_ready, register all request fields.
  - req_writeback=1 -> WB.
  - else req_cmd!=0 -> CMD.
  - else -> DONE with fill_valid=0.
- WB: bus_req=1, bus_write=1, bus_addr=victim_addr, bus_wdata=victim_data.
  - ack -> CMD if req_cmd!=0, else DONE.
- CMD: bus_req=1, bus_write=0, bus_cmd=req_cmd, bus_addr=req_addr.
  - ack -> DONE.
  - On ack, fill_data is captured from bus_rdata unless the command is bus_upgrade.
- NACK, any bus phase:
  - Increment retry counter, go to BACKOFF (bus_req=0 for exactly one cycle), then re-enter the same phase.
  - The NACK that makes the count equal MAX_RETRY goes to DONE with done_error=1, fill_state=I, fill_valid=0; remaining phases are skipped.
- Retry counter clears on each phase entry from IDLE or on phase change.
- ack and nack in the same cycle: ack wins.
- ack/nack while bus_req=0: ignored.
- DONE: done=1 for one cycle.
  - fill_valid=1 only for read/readex without error.
  - fill_state = registered req_state unless error.
  - Next cycle -> IDLE.
- fill_data/fill_state hold their value until the next DONE.
- Bus outputs are registered and stable for the whole time bus_req=1.
- Latency (accept in cycle 0): bus_req from cycle 1; ack in cycle 1 -> done in cycle 2, req_ready=1 in cycle 3. Each writeback phase adds ack latency + 1 cycle; each NACK adds 2 cycles.
- req_valid while busy: not accepted and not queued; the upstream holds it.

Test Plan:
- Reset, then read miss (cmd=bus_read, wb=0, addr=0x1000, state=S), ack in cycle 1 with rdata=0xA5..A5 -> bus_req cycles 1 only, done cycle 2, fill_valid=1, fill_data=0xA5..A5, fill_state=S.
- Write miss with writeback (cmd=bus_readex, wb=1, victim 0x2000) -> WB phase bus_write=1, addr 0x2000, wdata=victim; then CMD phase addr=req_addr; done with fill_state=M, fill_valid=1.
- Upgrade (cmd=bus_upgrade) ack with rdata=0xFF.. -> done, fill_valid=0, fill_data unchanged, fill_state=M.
- Two NACKs then ack, MAX_RETRY=4 -> bus_req pattern 1,0,1,0,1; done_error=0.
- Four NACKs in WB phase -> done_error=1, fill_state=I, no CMD phase issued.
- reset_n low while bus_req=1 -> bus_req=0 immediately; no done; req_ready=1. Also: ack+nack in the same cycle -> treated as ack.
